// File: rtl/reg_scoreboard.sv
// Register-occupancy scoreboard: per-register pending-writer counters that gate
// uop issue on RAW and counter-overflow hazards, claim destinations on issue
// and release them on write-back.
module reg_scoreboard #(
   parameter int unsigned NREGS = 32,
   parameter int unsigned IDX_W = 5,
   parameter int unsigned CNT_W = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 issue_valid,
   input  logic [2:0]           src_valid,
   input  logic [3*IDX_W-1:0]   src_idx,
   input  logic [1:0]           dst_valid,
   input  logic [2*IDX_W-1:0]   dst_idx,
   output logic                 issue_ok,
   input  logic [1:0]           wb_valid,
   input  logic [2*IDX_W-1:0]   wb_idx,
   input  logic                 flush,
   output logic [NREGS-1:0]     busy_vec,
   output logic [31:0]          stall_cnt,
   output logic                 err_underflow
);

   // Two extra bits hold cnt + 2 claims and a sign for cnt - 2 releases.
   localparam int unsigned        SUM_W   = CNT_W + 2;
   localparam logic [SUM_W-1:0]   CNT_MAX = SUM_W'((1 << CNT_W) - 1);

   logic [CNT_W-1:0]        cnt       [NREGS];
   logic [CNT_W-1:0]        cnt_nxt   [NREGS];
   logic [SUM_W-1:0]        dst_hits  [NREGS];
   logic [SUM_W-1:0]        wb_hits   [NREGS];
   logic signed [SUM_W-1:0] cnt_sum   [NREGS];
   logic [NREGS-1:0]        busy_nxt;
   logic                    raw_hazard;
   logic                    ovf_hazard;
   logic                    fire;
   logic                    underflow;

   // Per-register count of matching destination claims and write-back releases.
   always_comb begin
      for (int unsigned r = 0; r < NREGS; r++) begin
         dst_hits[r] = '0;
         wb_hits[r]  = '0;
         for (int unsigned j = 0; j < 2; j++) begin
            if (dst_valid[j] && (dst_idx[j*IDX_W +: IDX_W] == IDX_W'(r)))
               dst_hits[r] = dst_hits[r] + SUM_W'(1);
            if (wb_valid[j] && (wb_idx[j*IDX_W +: IDX_W] == IDX_W'(r)))
               wb_hits[r] = wb_hits[r] + SUM_W'(1);
         end
      end
   end

   // Hazard check against registered counters only; no same-cycle wb bypass.
   always_comb begin
      raw_hazard = 1'b0;
      ovf_hazard = 1'b0;
      for (int unsigned k = 0; k < 3; k++) begin
         if (src_valid[k] && (cnt[src_idx[k*IDX_W +: IDX_W]] != '0))
            raw_hazard = 1'b1;
      end
      for (int unsigned r = 0; r < NREGS; r++) begin
         if ((SUM_W'(cnt[r]) + dst_hits[r]) > CNT_MAX)
            ovf_hazard = 1'b1;
      end
      issue_ok = issue_valid && !raw_hazard && !ovf_hazard && !flush;
      fire     = issue_valid && issue_ok;
   end

   // Next counter values: cnt + claims - releases, clamped at zero; flush clears.
   always_comb begin
      underflow = 1'b0;
      busy_nxt  = '0;
      for (int unsigned r = 0; r < NREGS; r++) begin
         cnt_nxt[r] = '0;
         cnt_sum[r] = $signed(SUM_W'(cnt[r]))
                    + $signed(fire ? dst_hits[r] : SUM_W'(0))
                    - $signed(wb_hits[r]);
         if (flush) begin
            cnt_nxt[r] = '0;
         end else if (cnt_sum[r] < 0) begin
            cnt_nxt[r] = '0;
            underflow  = 1'b1;
         end else begin
            cnt_nxt[r] = CNT_W'(cnt_sum[r]);
         end
         busy_nxt[r] = (cnt_nxt[r] != '0);
      end
   end

   // Counter, busy, stall and sticky-error registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned r = 0; r < NREGS; r++) cnt[r] <= '0;
         busy_vec      <= '0;
         stall_cnt     <= '0;
         err_underflow <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         busy_vec <= busy_nxt;
         if (issue_valid && !issue_ok && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (underflow)
            err_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard: each vector drives one cycle of
// stimulus, checks issue_ok before the edge and the registered outputs after it.
module tb_reg_scoreboard;

   localparam int unsigned NREGS = 32;
   localparam int unsigned IDX_W = 5;
   localparam int unsigned CNT_W = 2;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 issue_valid;
   logic [2:0]           src_valid;
   logic [3*IDX_W-1:0]   src_idx;
   logic [1:0]           dst_valid;
   logic [2*IDX_W-1:0]   dst_idx;
   logic                 issue_ok;
   logic [1:0]           wb_valid;
   logic [2*IDX_W-1:0]   wb_idx;
   logic                 flush;
   logic [NREGS-1:0]     busy_vec;
   logic [31:0]          stall_cnt;
   logic                 err_underflow;

   typedef struct {
      logic        iv;
      logic [2:0]  sv;
      logic [14:0] si;
      logic [1:0]  dv;
      logic [9:0]  di;
      logic [1:0]  wv;
      logic [9:0]  wi;
      logic        fl;
      logic        ok;
      logic [31:0] busy;
      logic [31:0] stall;
      logic        err;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   reg_scoreboard #(.NREGS(NREGS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid),
      .src_valid(src_valid), .src_idx(src_idx), .dst_valid(dst_valid),
      .dst_idx(dst_idx), .issue_ok(issue_ok), .wb_valid(wb_valid),
      .wb_idx(wb_idx), .flush(flush), .busy_vec(busy_vec),
      .stall_cnt(stall_cnt), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [2:0] sv,
                               input int s0, input int s1, input int s2,
                               input logic [1:0] dv, input int d0, input int d1,
                               input logic [1:0] wv, input int w0, input int w1,
                               input logic fl, input logic ok,
                               input logic [31:0] busy, input int stall,
                               input logic err);
      vec_t v;
      v.iv = iv;  v.sv = sv;  v.si = {5'(s2), 5'(s1), 5'(s0)};
      v.dv = dv;  v.di = {5'(d1), 5'(d0)};
      v.wv = wv;  v.wi = {5'(w1), 5'(w0)};
      v.fl = fl;  v.ok = ok;  v.busy = busy;  v.stall = 32'(stall);  v.err = err;
      return v;
   endfunction

   // Drive at posedge+1, check issue_ok mid-cycle, check registered state after edge.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      issue_valid = v.iv;  src_valid = v.sv;  src_idx = v.si;
      dst_valid   = v.dv;  dst_idx   = v.di;
      wb_valid    = v.wv;  wb_idx    = v.wi;  flush = v.fl;
      #2;
      chk("issue_ok", idx, 32'(issue_ok), 32'(v.ok));
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("busy_vec", idx, busy_vec, e.busy);
      chk("stall_cnt", idx, stall_cnt, e.stall);
      chk("err_underflow", idx, 32'(err_underflow), 32'(e.err));
   endtask

   initial begin
      //            iv sv     s0 s1 s2 dv     d0 d1 wv     w0 w1 fl ok busy        stall err
      vecs.push_back(mk(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,   0, 0)); // 0 idle
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 3, 0, 2'b00, 0, 0, 0, 1, 32'h8,   0, 0)); // 1 claim 3
      vecs.push_back(mk(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 32'h8,   1, 0)); // 2 RAW
      vecs.push_back(mk(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b01, 3, 0, 0, 0, 32'h0,   2, 0)); // 3 RAW + wb 3
      vecs.push_back(mk(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,   2, 0)); // 4 now ok
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b11, 0, 2, 2'b00, 0, 0, 0, 1, 32'h5,   2, 0)); // 5 RAX/RDX
      vecs.push_back(mk(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b11, 0, 2, 0, 0, 32'h0,   2, 0)); // 6 dual wb
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 4, 0, 2'b00, 0, 0, 0, 1, 32'h10,  2, 0)); // 7 cnt4=1
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 4, 0, 2'b00, 0, 0, 0, 1, 32'h10,  2, 0)); // 8 cnt4=2
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 4, 0, 2'b00, 0, 0, 0, 1, 32'h10,  2, 0)); // 9 cnt4=3
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0, 32'h10,  3, 0)); // 10 overflow
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 4, 0, 2'b01, 4, 0, 0, 0, 32'h10,  4, 0)); // 11 ovf + wb -> 2
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 4, 0, 2'b00, 0, 0, 0, 1, 32'h10,  4, 0)); // 12 accepted -> 3
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b11, 4, 4, 2'b00, 0, 0, 0, 0, 32'h10,  5, 0)); // 13 double ovf
      vecs.push_back(mk(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b11, 4, 4, 0, 0, 32'h10,  5, 0)); // 14 -2 -> 1
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b11, 4, 4, 2'b00, 0, 0, 0, 1, 32'h10,  5, 0)); // 15 +2 -> 3
      vecs.push_back(mk(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b11, 4, 4, 0, 0, 32'h10,  5, 0)); // 16 -2 -> 1
      vecs.push_back(mk(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b10, 0, 4, 0, 0, 32'h0,   5, 0)); // 17 port1 -> 0
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0, 1, 32'h20,  5, 0)); // 18 claim 5
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b01, 5, 0, 0, 1, 32'h20,  5, 0)); // 19 claim+rel 5
      vecs.push_back(mk(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 5, 0, 0, 0, 32'h0,   5, 0)); // 20 rel 5
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b11, 1, 7, 2'b00, 0, 0, 0, 1, 32'h82,  5, 0)); // 21 claim 1,7
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 9, 0, 2'b00, 0, 0, 0, 1, 32'h282, 5, 0)); // 22 claim 9
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b01, 10,0, 2'b11, 1, 20,1, 0, 32'h0,   6, 0)); // 23 flush
      vecs.push_back(mk(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 7, 0, 0, 0, 32'h0,   6, 1)); // 24 underflow
      vecs.push_back(mk(1, 3'b111, 7, 9, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,   6, 1)); // 25 srcs free
      vecs.push_back(mk(1, 3'b000, 0, 0, 0, 2'b11, 6, 6, 2'b00, 0, 0, 0, 1, 32'h40,  6, 1)); // 26 cnt6=2
      vecs.push_back(mk(1, 3'b001, 6, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 32'h40,  7, 1)); // 27 RAW on 6

      reset_n = 1'b0;  issue_valid = 1'b0;  src_valid = '0;  src_idx = '0;
      dst_valid = '0;  dst_idx = '0;  wb_valid = '0;  wb_idx = '0;  flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", -1, busy_vec, 32'h0);
      chk("rst_stall", -1, stall_cnt, 32'h0);
      chk("rst_err", -1, 32'(err_underflow), 32'h0);
      chk("rst_issue_ok", -1, 32'(issue_ok), 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Async reset mid-cycle with cnt[6]=2 and the stalled uop still offered.
      issue_valid = 1'b1;  src_valid = 3'b001;  src_idx = 15'd6;
      dst_valid = '0;  wb_valid = '0;  flush = 1'b0;
      #2;
      chk("pre_arst_issue_ok", 100, 32'(issue_ok), 32'h0);
      reset_n = 1'b0;
      #1;
      chk("arst_busy", 100, busy_vec, 32'h0);
      chk("arst_stall", 100, stall_cnt, 32'h0);
      chk("arst_err", 100, 32'(err_underflow), 32'h0);
      chk("arst_issue_ok", 100, 32'(issue_ok), 32'h1);
      issue_valid = 1'b0;
      #1;
      chk("arst_issue_ok_idle", 101, 32'(issue_ok), 32'h0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_arst_busy", 102, busy_vec, 32'h0);
      chk("post_arst_stall", 102, stall_cnt, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
